// File: rtl/exception_ctrl_pkg.sv
// Shared constants for the memory-stage exception arbiter: CP0 exception codes,
// CP0 register numbers, status bit positions, flag bit positions and FSM states.
package exception_ctrl_pkg;

    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;

    // Bit positions inside exc_flags_i
    localparam int FLAG_ADEL_FETCH = 1;
    localparam int FLAG_RI         = 2;
    localparam int FLAG_SYSCALL    = 3;
    localparam int FLAG_BREAK      = 4;
    localparam int FLAG_OV         = 5;
    localparam int FLAG_TRAP       = 6;
    localparam int FLAG_ERET       = 7;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } exc_state_e;

    function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
        return status[STATUS_IE] & ~status[STATUS_EXL] & (|(cause[15:8] & status[15:8]));
    endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Combinational priority encoder: exception flags -> CP0 exception code and BadVAddr.
// The trap source participates only when EXC_TRAP_EN is defined.
module exc_priority_enc
    import exception_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              int_pend,
    input  logic [7:0]        exc_flags,
    input  logic              load_misalign,
    input  logic              store_misalign,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] mem_addr,
    output logic [31:0]       code,
    output logic [DATA_W-1:0] bad_addr
);

    logic trap_s;
    logic unused_s;

`ifdef EXC_TRAP_EN
    assign trap_s   = exc_flags[FLAG_TRAP];
    assign unused_s = exc_flags[0];
`else
    assign trap_s   = 1'b0;
    assign unused_s = ^{exc_flags[0], exc_flags[FLAG_TRAP]};
`endif

    // Highest-priority active source wins; lower ones are dropped
    always_comb begin
        code     = EXC_NONE;
        bad_addr = '0;
        if (int_pend) begin
            code = EXC_INT;
        end else if (exc_flags[FLAG_ADEL_FETCH]) begin
            code     = EXC_ADEL;
            bad_addr = pc;
        end else if (exc_flags[FLAG_RI]) begin
            code = EXC_RI;
        end else if (exc_flags[FLAG_SYSCALL]) begin
            code = EXC_SYS;
        end else if (exc_flags[FLAG_BREAK]) begin
            code = EXC_BP;
        end else if (trap_s) begin
            code = EXC_TR;
        end else if (exc_flags[FLAG_OV]) begin
            code = EXC_OV;
        end else if (load_misalign) begin
            code     = EXC_ADEL;
            bad_addr = mem_addr;
        end else if (store_misalign) begin
            code     = EXC_ADES;
            bad_addr = mem_addr;
        end else if (exc_flags[FLAG_ERET]) begin
            code = EXC_ERET;
        end else begin
            code     = EXC_NONE;
            bad_addr = '0;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Precise-exception arbiter for the memory stage: forwards in-flight CP0 writes,
// picks one exception, reports it to CP0 and redirects fetch. Optional: EXC_TRAP_EN.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid_i,
    input  logic              stall_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic              in_delayslot_i,
    input  logic [7:0]        exc_flags_i,
    input  logic              load_misalign_i,
    input  logic              store_misalign_i,
    input  logic [DATA_W-1:0] cp0_status_i,
    input  logic [DATA_W-1:0] cp0_cause_i,
    input  logic [DATA_W-1:0] cp0_epc_i,
    input  logic              cp0_we_i,
    input  logic [4:0]        cp0_waddr_i,
    input  logic [DATA_W-1:0] cp0_wdata_i,
    output logic [31:0]       excepttype_o,
    output logic [DATA_W-1:0] exc_pc_o,
    output logic              exc_delayslot_o,
    output logic [DATA_W-1:0] bad_addr_o,
    output logic              flush_o,
    output logic              newpc_valid_o,
    output logic [DATA_W-1:0] newpc_o,
    input  logic              pc_ready_i
);

    exc_state_e        state_r;
    exc_state_e        state_next_s;
    logic [DATA_W-1:0] newpc_r;
    logic [DATA_W-1:0] status_fwd_s;
    logic [DATA_W-1:0] cause_fwd_s;
    logic [DATA_W-1:0] epc_fwd_s;
    logic              int_pend_s;
    logic [31:0]       enc_code_s;
    logic [DATA_W-1:0] enc_bad_s;
    logic              take_s;
    logic [DATA_W-1:0] target_s;

    // Bypass the CP0 write in flight so arbitration sees this cycle's values
    always_comb begin
        status_fwd_s = cp0_status_i;
        cause_fwd_s  = cp0_cause_i;
        epc_fwd_s    = cp0_epc_i;
        if (cp0_we_i && (cp0_waddr_i == CP0_STATUS)) begin
            status_fwd_s = cp0_wdata_i;
        end else begin
            status_fwd_s = cp0_status_i;
        end
        // Only the software interrupt bits of cause are writable
        if (cp0_we_i && (cp0_waddr_i == CP0_CAUSE)) begin
            cause_fwd_s[9:8] = cp0_wdata_i[9:8];
        end else begin
            cause_fwd_s = cp0_cause_i;
        end
        if (cp0_we_i && (cp0_waddr_i == CP0_EPC)) begin
            epc_fwd_s = cp0_wdata_i;
        end else begin
            epc_fwd_s = cp0_epc_i;
        end
    end

    assign int_pend_s = int_pending(status_fwd_s, cause_fwd_s);

    exc_priority_enc #(
        .DATA_W(DATA_W)
    ) u_prio (
        .int_pend      (int_pend_s),
        .exc_flags     (exc_flags_i),
        .load_misalign (load_misalign_i),
        .store_misalign(store_misalign_i),
        .pc            (pc_i),
        .mem_addr      (mem_addr_i),
        .code          (enc_code_s),
        .bad_addr      (enc_bad_s)
    );

    assign take_s   = (state_r == ST_IDLE) && inst_valid_i && !stall_i && (enc_code_s != EXC_NONE);
    assign target_s = (enc_code_s == EXC_ERET) ? epc_fwd_s : EXC_VECTOR;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Redirect target, captured on the take cycle and held through the handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            newpc_r <= '0;
        end else if (take_s) begin
            newpc_r <= target_s;
        end else begin
            newpc_r <= newpc_r;
        end
    end

    assign newpc_o = newpc_r;

    // Next-state and CP0/flush outputs; the exception code is one-shot in IDLE
    always_comb begin
        state_next_s    = state_r;
        excepttype_o    = EXC_NONE;
        exc_pc_o        = '0;
        exc_delayslot_o = 1'b0;
        bad_addr_o      = '0;
        flush_o         = 1'b0;
        newpc_valid_o   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    excepttype_o    = enc_code_s;
                    exc_pc_o        = pc_i;
                    exc_delayslot_o = in_delayslot_i;
                    bad_addr_o      = enc_bad_s;
                    flush_o         = 1'b1;
                    state_next_s    = ST_REDIRECT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                flush_o       = 1'b1;
                newpc_valid_o = 1'b1;
                if (pc_ready_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REDIRECT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios plus randomized
// stimulus checked against a priority-list reference model.
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef EXC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, stall, in_ds, lm, sm, we, pc_ready;
    logic [31:0] pc, mem_addr, status, cause, epc, wdata;
    logic [7:0]  flags;
    logic [4:0]  waddr;
    logic [31:0] excepttype, exc_pc, bad_addr, newpc;
    logic        exc_ds, flush, newpc_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exception_ctrl dut (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid), .stall_i(stall), .pc_i(pc),
        .mem_addr_i(mem_addr), .in_delayslot_i(in_ds), .exc_flags_i(flags),
        .load_misalign_i(lm), .store_misalign_i(sm), .cp0_status_i(status),
        .cp0_cause_i(cause), .cp0_epc_i(epc), .cp0_we_i(we), .cp0_waddr_i(waddr),
        .cp0_wdata_i(wdata), .excepttype_o(excepttype), .exc_pc_o(exc_pc),
        .exc_delayslot_o(exc_ds), .bad_addr_o(bad_addr), .flush_o(flush),
        .newpc_valid_o(newpc_valid), .newpc_o(newpc), .pc_ready_i(pc_ready)
    );

    // Reference: forwarded CP0 view, then first active source in a priority list
    function automatic void ref_model(
        input logic [31:0] st_in, ca_in, ep_in, input logic we_in, input logic [4:0] wa,
        input logic [31:0] wd, input logic [7:0] fl, input logic lm_in, sm_in,
        input logic [31:0] pc_in, ma, output logic [31:0] code, bad, tgt);
        logic [31:0] st, ca, ep;
        bit          irq, found;
        bit          act [10];
        logic [31:0] codes [10];
        logic [31:0] bads [10];
        st = (we_in && wa == 5'd12) ? wd : st_in;
        ca = ca_in;
        if (we_in && wa == 5'd13) ca[9:8] = wd[9:8];
        ep = (we_in && wa == 5'd14) ? wd : ep_in;
        irq = (st[0] == 1'b1) && (st[1] == 1'b0) && ((ca[15:8] & st[15:8]) != 8'h00);
        act   = '{irq, fl[1], fl[2], fl[3], fl[4], TRAP_EN && fl[6], fl[5], lm_in, sm_in, fl[7]};
        codes = '{32'h1, 32'h4, 32'ha, 32'h8, 32'h9, 32'hd, 32'hc, 32'h4, 32'h5, 32'he};
        bads  = '{32'h0, pc_in, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ma, ma, 32'h0};
        code = 32'h0; bad = 32'h0; found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (act[i] && !found) begin
                code = codes[i]; bad = bads[i]; found = 1'b1;
            end
        end
        tgt = (code == 32'he) ? ep : VEC;
    endfunction

    task automatic idle_inputs();
        inst_valid = 1'b0; stall = 1'b0; pc = 32'h0; mem_addr = 32'h0; in_ds = 1'b0;
        flags = 8'h00; lm = 1'b0; sm = 1'b0; status = 32'h0; cause = 32'h0; epc = 32'h0;
        we = 1'b0; waddr = 5'd0; wdata = 32'h0; pc_ready = 1'b0;
    endtask

    // Finish an open redirect: accept on the next edge, land in IDLE
    task automatic drain();
        @(negedge clk); idle_inputs(); pc_ready = 1'b1;
        @(negedge clk); pc_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs(); rst = 1'b0; #3;
        checks++;
        if ({excepttype, exc_pc, bad_addr, newpc, exc_ds, flush, newpc_valid} !== '0) begin
            errors++; $display("FAIL reset_outputs got type=%h pc=%h newpc=%h flush=%b valid=%b required all 0", excepttype, exc_pc, newpc, flush, newpc_valid);
        end
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if ({flush, newpc_valid, excepttype} !== '0) begin
            errors++; $display("FAIL reset_release got flush=%b valid=%b type=%h required 0", flush, newpc_valid, excepttype);
        end
    endtask

    task automatic test_syscall();
        @(negedge clk); idle_inputs(); inst_valid = 1'b1; pc = 32'hBFC0_0100; flags = 8'h08; #1;
        checks++;
        if (excepttype !== 32'h8 || exc_pc !== 32'hBFC0_0100 || flush !== 1'b1 || exc_ds !== 1'b0 || newpc_valid !== 1'b0) begin
            errors++; $display("FAIL syscall_take got type=%h pc=%h flush=%b ds=%b valid=%b required 8 bfc00100 1 0 0", excepttype, exc_pc, flush, exc_ds, newpc_valid);
        end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (newpc_valid !== 1'b1 || newpc !== VEC || excepttype !== 32'h0 || flush !== 1'b1) begin
            errors++; $display("FAIL syscall_redirect got valid=%b newpc=%h type=%h flush=%b required 1 %h 0 1", newpc_valid, newpc, excepttype, flush, VEC);
        end
        drain(); #1;
        checks++;
        if (newpc_valid !== 1'b0 || flush !== 1'b0) begin
            errors++; $display("FAIL syscall_back_idle got valid=%b flush=%b required 0 0", newpc_valid, flush);
        end
    endtask

    task automatic test_interrupt();
        @(negedge clk); idle_inputs(); inst_valid = 1'b1; pc = 32'h8000_1000;
        status = 32'h0000_0401; cause = 32'h0000_0400; #1;
        checks++;
        if (excepttype !== 32'h1 || exc_pc !== 32'h8000_1000) begin
            errors++; $display("FAIL irq_take got type=%h pc=%h required 1 80001000", excepttype, exc_pc);
        end
        drain();
        @(negedge clk); inst_valid = 1'b1; pc = 32'h8000_1004; status = 32'h0000_0403; cause = 32'h0000_0400; #1;
        checks++;
        if (excepttype !== 32'h0 || flush !== 1'b0) begin
            errors++; $display("FAIL irq_exl_masked got type=%h flush=%b required 0 0", excepttype, flush);
        end
        // Interrupt beats an eret sitting in the memory stage
        @(negedge clk); status = 32'h0000_0401; flags = 8'h80; epc = 32'h1234_5678; pc = 32'h8000_2000; #1;
        checks++;
        if (excepttype !== 32'h1 || exc_pc !== 32'h8000_2000) begin
            errors++; $display("FAIL irq_over_eret got type=%h pc=%h required 1 80002000", excepttype, exc_pc);
        end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (newpc !== VEC) begin
            errors++; $display("FAIL irq_over_eret_target got %h required %h", newpc, VEC);
        end
        drain();
    endtask

    task automatic test_load_misalign();
        @(negedge clk); idle_inputs(); inst_valid = 1'b1; pc = 32'h8000_0040;
        mem_addr = 32'h8000_0003; lm = 1'b1; in_ds = 1'b1; #1;
        checks++;
        if (excepttype !== 32'h4 || bad_addr !== 32'h8000_0003 || exc_ds !== 1'b1) begin
            errors++; $display("FAIL load_adel got type=%h bad=%h ds=%b required 4 80000003 1", excepttype, bad_addr, exc_ds);
        end
        drain();
    endtask

    task automatic test_eret_forward();
        @(negedge clk); idle_inputs(); inst_valid = 1'b1; pc = 32'h8000_0080; flags = 8'h80;
        epc = 32'h0000_0011; we = 1'b1; waddr = 5'd14; wdata = 32'hBFC0_0200; #1;
        checks++;
        if (excepttype !== 32'he) begin
            errors++; $display("FAIL eret_code got %h required e", excepttype);
        end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (newpc !== 32'hBFC0_0200 || newpc_valid !== 1'b1) begin
            errors++; $display("FAIL eret_epc_fwd got newpc=%h valid=%b required bfc00200 1", newpc, newpc_valid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        @(negedge clk); idle_inputs(); inst_valid = 1'b1; pc = 32'h8000_0100;
        flags = 8'h24; sm = 1'b1; mem_addr = 32'h8000_0102; #1;
        checks++;
        if (excepttype !== 32'ha || bad_addr !== 32'h0) begin
            errors++; $display("FAIL multi_flag got type=%h bad=%h required a 0", excepttype, bad_addr);
        end
        // Instruction stays valid in the slot: must not be reported again while held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); pc_ready = 1'b0; #1;
            checks++;
            if (newpc_valid !== 1'b1 || excepttype !== 32'h0 || newpc !== VEC) begin
                errors++; $display("FAIL hold_valid cyc%0d got valid=%b type=%h newpc=%h required 1 0 %h", i, newpc_valid, excepttype, newpc, VEC);
            end
        end
        @(negedge clk); pc_ready = 1'b1;
        @(negedge clk); pc_ready = 1'b0; #1;
        checks++;
        if (excepttype !== 32'ha || flush !== 1'b1) begin
            errors++; $display("FAIL spacing_retake got type=%h flush=%b required a 1", excepttype, flush);
        end
        drain();
    endtask

    task automatic test_trap();
        logic [31:0] exp_code;
        exp_code = TRAP_EN ? 32'hd : 32'h0;
        @(negedge clk); idle_inputs(); inst_valid = 1'b1; pc = 32'h8000_0200; flags = 8'h40; #1;
        checks++;
        if (excepttype !== exp_code || flush !== (exp_code != 32'h0)) begin
            errors++; $display("FAIL trap got type=%h flush=%b required %h", excepttype, flush, exp_code);
        end
        if (exp_code != 32'h0) drain();
    endtask

    task automatic test_stall();
        @(negedge clk); idle_inputs(); inst_valid = 1'b1; stall = 1'b1; pc = 32'h8000_0300; flags = 8'h10; #1;
        checks++;
        if ({excepttype, exc_pc, bad_addr, exc_ds, flush, newpc_valid} !== '0) begin
            errors++; $display("FAIL stall_quiet got type=%h flush=%b required all 0", excepttype, flush);
        end
        @(negedge clk); #1;
        checks++;
        if (newpc_valid !== 1'b0 || flush !== 1'b0) begin
            errors++; $display("FAIL stall_no_redirect got valid=%b flush=%b required 0 0", newpc_valid, flush);
        end
        stall = 1'b0; #1;
        checks++;
        if (excepttype !== 32'h9 || exc_pc !== 32'h8000_0300) begin
            errors++; $display("FAIL stall_release got type=%h pc=%h required 9 80000300", excepttype, exc_pc);
        end
        drain();
    endtask

    task automatic test_reset_mid_redirect();
        @(negedge clk); idle_inputs(); inst_valid = 1'b1; pc = 32'h8000_0400; flags = 8'h08;
        @(negedge clk); idle_inputs(); #2;
        rst = 1'b0; #1;
        checks++;
        if ({excepttype, exc_pc, bad_addr, newpc, exc_ds, flush, newpc_valid} !== '0) begin
            errors++; $display("FAIL reset_mid_redirect got valid=%b flush=%b newpc=%h required all 0", newpc_valid, flush, newpc);
        end
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if (newpc_valid !== 1'b0 || flush !== 1'b0) begin
            errors++; $display("FAIL reset_mid_redirect_idle got valid=%b flush=%b required 0 0", newpc_valid, flush);
        end
    endtask

    task automatic test_random();
        bit          busy;
        int          wait_cyc;
        logic [31:0] e_code, e_bad, e_tgt, tgt;
        bit          take;
        busy = 1'b0; wait_cyc = 0; tgt = 32'h0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            inst_valid = ($urandom_range(0, 4) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            pc = $urandom; mem_addr = $urandom; in_ds = 1'($urandom_range(0, 1));
            flags = 8'($urandom & $urandom & $urandom) & 8'hFE;
            lm = ($urandom_range(0, 5) == 0); sm = ($urandom_range(0, 5) == 0);
            status = $urandom; status[0] = 1'($urandom_range(0, 1)); status[1] = ($urandom_range(0, 3) == 0);
            cause = $urandom; epc = $urandom; wdata = $urandom;
            we = 1'($urandom_range(0, 1)); waddr = 5'($urandom_range(11, 15));
            if (!busy) begin
                pc_ready = 1'($urandom_range(0, 1));
                ref_model(status, cause, epc, we, waddr, wdata, flags, lm, sm, pc, mem_addr, e_code, e_bad, e_tgt);
                take = inst_valid && !stall && (e_code != 32'h0);
                #1;
                checks++;
                if (excepttype !== (take ? e_code : 32'h0) || flush !== take || newpc_valid !== 1'b0 ||
                    exc_pc !== (take ? pc : 32'h0) || bad_addr !== (take ? e_bad : 32'h0) || exc_ds !== (take && in_ds)) begin
                    errors++; $display("FAIL rand_idle n=%0d got type=%h pc=%h bad=%h ds=%b flush=%b valid=%b required type=%h bad=%h take=%b",
                                       n, excepttype, exc_pc, bad_addr, exc_ds, flush, newpc_valid, take ? e_code : 32'h0, take ? e_bad : 32'h0, take);
                end
                if (take) begin
                    busy = 1'b1; tgt = e_tgt; wait_cyc = $urandom_range(0, 3);
                end
            end else begin
                pc_ready = (wait_cyc == 0);
                #1;
                checks++;
                if (newpc_valid !== 1'b1 || newpc !== tgt || excepttype !== 32'h0 || flush !== 1'b1) begin
                    errors++; $display("FAIL rand_redirect n=%0d got valid=%b newpc=%h type=%h flush=%b required 1 %h 0 1",
                                       n, newpc_valid, newpc, excepttype, flush, tgt);
                end
                if (wait_cyc == 0) busy = 1'b0;
                else wait_cyc--;
            end
        end
        if (busy) drain();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_syscall();
        test_interrupt();
        test_load_misalign();
        test_eret_forward();
        test_back_to_back();
        test_trap();
        test_stall();
        test_reset_mid_redirect();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
